// File: rtl/counting_gen_pkg.sv
// Shared definitions for the 1-2-3 marker generator and its detector partner.
// Holds the 2-bit symbol constants and the generator FSM state encoding.
package counting_gen_pkg;

    localparam logic [1:0] SYM_FILL = 2'b00;
    localparam logic [1:0] SYM_1    = 2'b01;
    localparam logic [1:0] SYM_2    = 2'b10;
    localparam logic [1:0] SYM_3    = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        M1   = 3'd2,
        M2   = 3'd3,
        M3   = 3'd4,
        FIN  = 3'd5
    } gen_state_t;

endpackage

// File: rtl/counting_gen_gap.sv
// Filler-gap down-counter.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   load         load load_val into the counter (wins over dec)
//   load_val     gap length to count down from
//   dec          decrement by one (ignored when already zero)
//   zero_next    a decrement this cycle would bring the count to zero
module gap_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_next
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_next = (cnt_q == W'(1));

endmodule

// File: rtl/counting_gen.sv
// Marker-stream generator: emits reps markers (1,2,3), each preceded by gap
// filler symbols, over a valid/ready handshake. All outputs are registered.
// Ports:
//   start/reps/gap  burst request; reps/gap latched when start is taken in IDLE
//   ready           sink accepts num this cycle
//   num/valid       current symbol and its qualifier
//   busy            any state but IDLE
//   done            single-cycle pulse in FIN
//   marks_sent      markers completed in the current or last burst
//
// state | meaning
// IDLE  | waiting for start, valid low
// GAP   | sending filler symbols, gap counter running
// M1    | sending marker symbol 1
// M2    | sending marker symbol 2
// M3    | sending marker symbol 3, marker counted on transfer
// FIN   | burst finished, done high for one cycle
module counting_gen
    import counting_gen_pkg::*;
#(
    parameter int         REP_W = 4,
    parameter int         GAP_W = 4,
    parameter logic [1:0] FILL  = SYM_FILL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic [GAP_W-1:0] gap,
    input  logic             ready,
    output logic [1:0]       num,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] marks_sent
);

    gen_state_t       state_q, state_d;
    logic [REP_W-1:0] reps_q, reps_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [REP_W-1:0] marks_q, marks_d;
    logic [1:0]       num_q, num_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             xfer;
    logic             cnt_load;
    logic [GAP_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero_next;

    gap_counter #(.W(GAP_W)) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (cnt_load),
        .load_val  (cnt_load_val),
        .dec       (cnt_dec),
        .zero_next (cnt_zero_next)
    );

    assign xfer = valid_q && ready;

    always_comb begin
        state_d      = state_q;
        reps_d       = reps_q;
        gap_d        = gap_q;
        marks_d      = marks_q;
        cnt_load     = 1'b0;
        cnt_load_val = gap_q;
        cnt_dec      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    reps_d       = reps;
                    gap_d        = gap;
                    marks_d      = '0;
                    cnt_load_val = gap;
                    if (reps == '0) begin
                        state_d = FIN;
                    end else if (gap != '0) begin
                        cnt_load = 1'b1;
                        state_d  = GAP;
                    end else begin
                        state_d = M1;
                    end
                end
            end
            GAP: begin
                if (xfer) begin
                    cnt_dec = 1'b1;
                    if (cnt_zero_next) begin
                        state_d = M1;
                    end
                end
            end
            M1: if (xfer) state_d = M2;
            M2: if (xfer) state_d = M3;
            M3: begin
                if (xfer) begin
                    marks_d = marks_q + 1'b1;
                    if (marks_d == reps_q) begin
                        state_d = FIN;
                    end else if (gap_q != '0) begin
                        cnt_load = 1'b1;
                        state_d  = GAP;
                    end else begin
                        state_d = M1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they land in flops
        // together with the state they describe.
        num_d   = 2'b00;
        valid_d = 1'b0;
        unique case (state_d)
            GAP:     begin num_d = FILL;  valid_d = 1'b1; end
            M1:      begin num_d = SYM_1; valid_d = 1'b1; end
            M2:      begin num_d = SYM_2; valid_d = 1'b1; end
            M3:      begin num_d = SYM_3; valid_d = 1'b1; end
            default: begin num_d = 2'b00; valid_d = 1'b0; end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            reps_q  <= '0;
            gap_q   <= '0;
            marks_q <= '0;
            num_q   <= 2'b00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            marks_q <= marks_d;
            num_q   <= num_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign num        = num_q;
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign marks_sent = marks_q;

endmodule
